// File: rtl/intercal_alu_iter_pkg.sv
// Shared opcode constants and FSM state encoding for the INTERCAL iterative ALU.
package intercal_pkg;

    localparam logic [3:0] OP_A         = 4'd0;
    localparam logic [3:0] OP_B         = 4'd1;
    localparam logic [3:0] OP_AND16     = 4'd2;
    localparam logic [3:0] OP_AND32     = 4'd3;
    localparam logic [3:0] OP_OR16      = 4'd4;
    localparam logic [3:0] OP_OR32      = 4'd5;
    localparam logic [3:0] OP_XOR16     = 4'd6;
    localparam logic [3:0] OP_XOR32     = 4'd7;
    localparam logic [3:0] OP_MINGLE_LO = 4'd8;
    localparam logic [3:0] OP_MINGLE_HI = 4'd9;
    localparam logic [3:0] OP_SEL16     = 4'd10;
    localparam logic [3:0] OP_SEL32     = 4'd11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/intercal_select_engine.sv
// Bit-serial INTERCAL select: scans b MSB-first in every lane at once, packing the
// a bits under set b bits right-justified. The start edge already processes the top bit.
module intercal_select_engine #(
    parameter int LANE_W = 32,
    parameter int LANES  = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LANES*LANE_W-1:0]   a,
    input  logic [LANES*LANE_W-1:0]   b,
    output logic                      done,
    output logic [LANES*LANE_W-1:0]   result
);
    localparam int CW = $clog2(LANE_W);
    localparam int N  = LANES * LANE_W;

    logic [N-1:0]  a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [N-1:0]  src_a, src_b, base;
    logic [CW-1:0] cnt_q, cnt_d, idx;
    logic          busy_q, busy_d;

    always_comb begin
        src_a  = start ? a : a_q;
        src_b  = start ? b : b_q;
        base   = start ? '0 : acc_q;
        idx    = start ? CW'(LANE_W - 1) : cnt_q;
        acc_d  = acc_q;
        a_d    = a_q;
        b_d    = b_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (start || busy_q) begin
            for (int l = 0; l < LANES; l++) begin
                if (src_b[l*LANE_W + int'(idx)])
                    acc_d[l*LANE_W +: LANE_W] = {base[l*LANE_W +: LANE_W-1], src_a[l*LANE_W + int'(idx)]};
                else
                    acc_d[l*LANE_W +: LANE_W] = base[l*LANE_W +: LANE_W];
            end
        end
        if (start) begin
            a_d    = a;
            b_d    = b;
            cnt_d  = CW'(LANE_W - 2);
            busy_d = 1'b1;
        end else if (busy_q) begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == '0)
                busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    // The caller registers the value being formed on the final scan edge.
    assign done   = busy_q && (cnt_q == '0);
    assign result = acc_d;

endmodule

// File: rtl/intercal_alu_iter.sv
// INTERCAL ALU with valid/ready handshakes. Define INTERCAL_ALU_ITER_SELECT_EN to build the
// iterative select engine for ops 10/11; otherwise those opcodes report err like 12-15.
module intercal_alu_iter
    import intercal_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       s,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic             err
);
    localparam int H = WIDTH / 2;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] f_q, f_d;
    logic             err_q, err_d, out_valid_q, out_valid_d, live_q;
    logic             accept, is_select, sel_done;
    logic [WIDTH-1:0] sel_result, op_f, rot_full, rot_lanes, m_lo, m_hi;
    logic             op_err;

    assign in_ready = live_q && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign accept   = in_valid && in_ready;

`ifdef INTERCAL_ALU_ITER_SELECT_EN
    logic             start16, start32, done16, done32;
    logic [WIDTH-1:0] res16, res32;

    assign start16   = accept && (s == OP_SEL16);
    assign start32   = accept && (s == OP_SEL32);
    assign is_select = (s == OP_SEL16) || (s == OP_SEL32);

    intercal_select_engine #(.LANE_W(H), .LANES(2)) u_sel16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .a(a), .b(b), .done(done16), .result(res16)
    );
    intercal_select_engine #(.LANE_W(WIDTH), .LANES(1)) u_sel32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a), .b(b), .done(done32), .result(res32)
    );

    assign sel_done   = done16 || done32;
    assign sel_result = done16 ? res16 : res32;
`else
    assign is_select  = 1'b0;
    assign sel_done   = 1'b0;
    assign sel_result = '0;
`endif

    always_comb begin
        rot_full  = {a[0], a[WIDTH-1:1]};
        rot_lanes = {a[H], a[WIDTH-1:H+1], a[0], a[H-1:1]};
        m_lo      = '0;
        m_hi      = '0;
        for (int i = 0; i < H; i++) begin
            m_lo[2*i+1] = a[i];
            m_lo[2*i]   = b[i];
            m_hi[2*i+1] = a[H+i];
            m_hi[2*i]   = b[H+i];
        end
        op_f   = '0;
        op_err = 1'b0;
        case (s)
            OP_A:         op_f = a;
            OP_B:         op_f = b;
            OP_AND16:     op_f = a & rot_lanes;
            OP_AND32:     op_f = a & rot_full;
            OP_OR16:      op_f = a | rot_lanes;
            OP_OR32:      op_f = a | rot_full;
            OP_XOR16:     op_f = a ^ rot_lanes;
            OP_XOR32:     op_f = a ^ rot_full;
            OP_MINGLE_LO: op_f = m_lo;
            OP_MINGLE_HI: op_f = m_hi;
            default:      op_err = 1'b1;
        endcase
    end

    // Completion is applied first so a same-edge acceptance in DONE overrides it.
    always_comb begin
        state_d = state_q;
        f_d     = f_q;
        err_d   = err_q;
        if ((state_q == ST_DONE) && out_ready)
            state_d = ST_IDLE;
        if ((state_q == ST_BUSY) && sel_done) begin
            state_d = ST_DONE;
            f_d     = sel_result;
            err_d   = 1'b0;
        end
        if (accept) begin
            if (is_select) begin
                state_d = ST_BUSY;
            end else begin
                state_d = ST_DONE;
                f_d     = op_f;
                err_d   = op_err;
            end
        end
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            f_q         <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            live_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            f_q         <= f_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            live_q      <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign f         = f_q;
    assign err       = err_q;

endmodule

// File: tb/tb_intercal_alu_iter.sv
// Directed self-checking bench for intercal_alu_iter (WIDTH=32); select-op expectations
// follow whether INTERCAL_ALU_ITER_SELECT_EN is defined.
module tb_intercal_alu_iter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s;
    logic [31:0] a, b, f;
    logic        in_valid, in_ready, out_valid, out_ready, err;
    int          total = 0;
    int          bad   = 0;

    intercal_alu_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .s(s), .a(a), .b(b),
        .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready),
        .f(f), .err(err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    task automatic issue(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
        int n;
        @(negedge clk);
        s = op; a = av; b = bv; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (n >= 50) begin
            bad++;
            $display("[TB] FAIL issue_ready in_ready=%b want 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s = '0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("[TB] FAIL reset_in_ready got %b want 0", in_ready); end
        total++; if (f !== 32'h0)        begin bad++; $display("[TB] FAIL reset_f got %h want 0", f); end
        total++; if (err !== 1'b0)       begin bad++; $display("[TB] FAIL reset_err got %b want 0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0)  begin bad++; $display("[TB] FAIL release_before_edge in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL release_after_edge in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_unary();
        logic [3:0]  ops  [6] = '{4'd3, 4'd6, 4'd2, 4'd5, 4'd7, 4'd4};
        logic [31:0] avs  [6] = '{32'h80000001, 32'h00010001, 32'h00030003, 32'h00000001, 32'hFFFFFFFF, 32'h00010000};
        logic [31:0] exps [6] = '{32'h80000000, 32'h80018001, 32'h00010001, 32'h80000001, 32'h00000000, 32'h80010000};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], avs[i], 32'h0);
            wait_done(lat);
            total++; if (f !== exps[i]) begin bad++; $display("[TB] FAIL unary[%0d] f got %h want %h", i, f, exps[i]); end
            total++; if (err !== 1'b0)  begin bad++; $display("[TB] FAIL unary[%0d] err got %b want 0", i, err); end
            total++; if (lat !== 1)     begin bad++; $display("[TB] FAIL unary[%0d] latency got %0d want 1", i, lat); end
            pop();
        end
    endtask

    task automatic test_mingle_pass();
        logic [3:0]  ops  [6] = '{4'd8, 4'd9, 4'd8, 4'd9, 4'd0, 4'd1};
        logic [31:0] avs  [6] = '{32'h0000FFFF, 32'h0, 32'h00000001, 32'h00010000, 32'h5, 32'h0};
        logic [31:0] bvs  [6] = '{32'h0, 32'hFFFF0000, 32'h00000003, 32'h0, 32'h0, 32'hDEADBEEF};
        logic [31:0] exps [6] = '{32'hAAAAAAAA, 32'h55555555, 32'h00000007, 32'h00000002, 32'h5, 32'hDEADBEEF};
        int lat;
        for (int i = 0; i < 6; i++) begin
            issue(ops[i], avs[i], bvs[i]);
            wait_done(lat);
            total++; if (f !== exps[i]) begin bad++; $display("[TB] FAIL mingle_pass[%0d] f got %h want %h", i, f, exps[i]); end
            total++; if (err !== 1'b0)  begin bad++; $display("[TB] FAIL mingle_pass[%0d] err got %b want 0", i, err); end
            total++; if (lat !== 1)     begin bad++; $display("[TB] FAIL mingle_pass[%0d] latency got %0d want 1", i, lat); end
            pop();
        end
    endtask

    task automatic test_errors();
        int lat;
        for (int op = 12; op < 16; op++) begin
            issue(4'(op), 32'hFFFFFFFF, 32'hFFFFFFFF);
            wait_done(lat);
            total++; if (f !== 32'h0)  begin bad++; $display("[TB] FAIL err_op%0d f got %h want 0", op, f); end
            total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL err_op%0d err got %b want 1", op, err); end
            total++; if (lat !== 1)    begin bad++; $display("[TB] FAIL err_op%0d latency got %0d want 1", op, lat); end
            pop();
        end
    endtask

    task automatic test_select();
        int lat;
`ifdef INTERCAL_ALU_ITER_SELECT_EN
        logic [31:0] avs  [3] = '{32'h12345678, 32'h12345678, 32'h80000000};
        logic [31:0] bvs  [3] = '{32'h0000FFFF, 32'h00000000, 32'h80000001};
        logic [31:0] exps [3] = '{32'h00005678, 32'h00000000, 32'h00000002};
        for (int i = 0; i < 3; i++) begin
            issue(4'd11, avs[i], bvs[i]);
            wait_done(lat);
            total++; if (f !== exps[i]) begin bad++; $display("[TB] FAIL sel32[%0d] f got %h want %h", i, f, exps[i]); end
            total++; if (err !== 1'b0)  begin bad++; $display("[TB] FAIL sel32[%0d] err got %b want 0", i, err); end
            total++; if (lat !== 32)    begin bad++; $display("[TB] FAIL sel32[%0d] latency got %0d want 32", i, lat); end
            pop();
        end
        issue(4'd10, 32'hFFFF1234, 32'h00FF00FF);
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (lat == 3) begin
                s = 4'd0; a = 32'hABCD0000; b = 32'h0; in_valid = 1'b1;
            end
            if (lat == 4) begin
                total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL sel16_busy in_ready got %b want 0", in_ready); end
            end
            if (lat == 6) in_valid = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        total++; if (f !== 32'h00FF0034) begin bad++; $display("[TB] FAIL sel16 f got %h want 00ff0034", f); end
        total++; if (err !== 1'b0)       begin bad++; $display("[TB] FAIL sel16 err got %b want 0", err); end
        total++; if (lat !== 16)         begin bad++; $display("[TB] FAIL sel16 latency got %0d want 16", lat); end
        pop();
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL sel16_ignored out_valid got %b want 0", out_valid); end
`else
        for (int op = 10; op < 12; op++) begin
            issue(4'(op), 32'hFFFF1234, 32'h00FF00FF);
            wait_done(lat);
            total++; if (f !== 32'h0)  begin bad++; $display("[TB] FAIL sel_off_op%0d f got %h want 0", op, f); end
            total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL sel_off_op%0d err got %b want 1", op, err); end
            total++; if (lat !== 1)    begin bad++; $display("[TB] FAIL sel_off_op%0d latency got %0d want 1", op, lat); end
            pop();
        end
`endif
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(4'd1, 32'h0, 32'h00001234);
        wait_done(lat);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++; if (f !== 32'h00001234 || out_valid !== 1'b1) begin
                bad++; $display("[TB] FAIL hold[%0d] f=%h out_valid=%b want 00001234/1", i, f, out_valid);
            end
        end
        @(negedge clk);
        out_ready = 1'b1; s = 4'd0; a = 32'h5; b = 32'h0; in_valid = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL b2b_in_ready got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("[TB] FAIL b2b_out_valid got %b want 1", out_valid); end
        total++; if (f !== 32'h5)        begin bad++; $display("[TB] FAIL b2b_f got %h want 5", f); end
        total++; if (err !== 1'b0)       begin bad++; $display("[TB] FAIL b2b_err got %b want 0", err); end
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL b2b_drain out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        issue(4'd11, 32'h12345678, 32'hFFFFFFFF);
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_out_valid got %b want 0", out_valid); end
        total++; if (in_ready !== 1'b0)  begin bad++; $display("[TB] FAIL midrst_in_ready got %b want 0", in_ready); end
        total++; if (f !== 32'h0)        begin bad++; $display("[TB] FAIL midrst_f got %h want 0", f); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("[TB] FAIL midrst_release in_ready got %b want 1", in_ready); end
        repeat (40) @(posedge clk);
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_aborted out_valid got %b want 0", out_valid); end
        issue(4'd13, 32'h12345678, 32'h9ABCDEF0);
        wait_done(lat);
        total++; if (err !== 1'b1) begin bad++; $display("[TB] FAIL midrst_op13 err got %b want 1", err); end
        total++; if (f !== 32'h0)  begin bad++; $display("[TB] FAIL midrst_op13 f got %h want 0", f); end
        total++; if (lat !== 1)    begin bad++; $display("[TB] FAIL midrst_op13 latency got %0d want 1", lat); end
        pop();
    endtask

    initial begin
        test_reset();
        test_unary();
        test_mingle_pass();
        test_errors();
        test_select();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intercal_alu_iter.md
INTERCAL_ALU_ITER -- requirements
Module: intercal_alu_iter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, giving the operand and result width; it SHALL be even and at least 4, and H = WIDTH/2.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port s, input, 4 bits: opcode, sampled on acceptance.
REQ-005 The module SHALL have ports a and b, input, WIDTH bits each: operands, sampled on acceptance.
REQ-006 The module SHALL have ports in_valid (input, 1) and in_ready (output, 1): request handshake.
REQ-007 The module SHALL have ports out_valid (output, 1) and out_ready (input, 1): response handshake.
REQ-008 The module SHALL have port f, output, WIDTH bits: result, meaningful while out_valid=1.
REQ-009 The module SHALL have port err, output, 1 bit: unsupported opcode, meaningful while out_valid=1.

Function
REQ-010 A request SHALL be accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-011 The FSM states SHALL be IDLE, BUSY and DONE.
- IDLE: on accept, go to DONE for non-select ops, or to BUSY for ops 10/11.
- BUSY: when the last bit is processed, go to DONE.
- DONE: on out_ready=1, go to IDLE, or to DONE/BUSY if a new request is accepted on the same edge.
REQ-012 in_ready SHALL equal (state==IDLE) | (state==DONE & out_ready); a completing response and a new acceptance on the same edge SHALL both take effect.
REQ-013 out_valid SHALL be 1 exactly in DONE; f and err SHALL be stable from entry to DONE until the out_ready handshake.
REQ-014 Ops 0-9 and 12-15 SHALL reach DONE on the first edge after acceptance (latency 1).
REQ-015 Op semantics, with rot(x) = {x[0], x[n-1:1]} applied per lane, SHALL be:
- 0: a; 1: b.
- 2/4/6: unary AND/OR/XOR over two H-bit lanes.
- 3/5/7: unary AND/OR/XOR over one WIDTH-bit lane.
- 8: mingle of a[H-1:0] with b[H-1:0], with a bits at odd positions.
- 9: the same mingle using the upper halves.
REQ-016 Op 11 (select WIDTH) SHALL scan b from bit WIDTH-1 down to 0, one bit per cycle; for each set b[i], the accumulator shifts left and inserts a[i]; the result is right-justified and zero-filled; out_valid SHALL rise WIDTH cycles after acceptance.
REQ-017 Op 10 (select per H-lane) SHALL scan both lanes in parallel, one bit per lane per cycle; the result is {selH, selL}; out_valid SHALL rise H cycles after acceptance.
REQ-018 Latency SHALL be independent of operand values; in particular b=0 SHALL still take the full scan and give f=0.
REQ-019 Opcodes 12-15 SHALL give f=0 and err=1; all other ops SHALL give err=0.
REQ-020 in_valid asserted while BUSY SHALL be ignored, and the operands latched at acceptance SHALL be used for the whole scan.

Reset
REQ-021 With rst_n=0, the state SHALL go to IDLE immediately, regardless of clk.
REQ-022 During reset, out_valid=0, f=0, err=0 and in_ready=0; the scan counter and accumulators SHALL be 0.
REQ-023 Reset asserted in BUSY or DONE SHALL abort the operation with no response.
REQ-024 in_ready SHALL rise on the first clk edge after rst_n deasserts.

Configuration
REQ-025 The macro INTERCAL_ALU_ITER_SELECT_EN SHALL control the iterative select engine.
REQ-026 With INTERCAL_ALU_ITER_SELECT_EN defined, ops 10/11 SHALL behave per REQ-016/017.
REQ-027 With INTERCAL_ALU_ITER_SELECT_EN undefined, the engine SHALL be removed and ops 10/11 SHALL behave as ops 12-15: latency 1, f=0, err=1.

Structure
REQ-028 Shared package intercal_pkg SHALL hold the opcode constants (OP_A..OP_SEL32, 0-11) and the FSM state encoding.
REQ-029 The select datapath SHALL be the sub-module intercal_select_engine.
- Parameters: lane width and lane count.
- Inputs: start, operands.
- Outputs: done, result.
REQ-030 All other ops SHALL be computed combinationally and registered into f on acceptance.

Verification (WIDTH=32)
REQ-031 Op 3, a=0x80000001 -> f=0x80000000, err=0, out_valid one cycle after accept.
REQ-032 Op 8, a=0x0000FFFF, b=0 -> f=0xAAAAAAAA; op 6, a=0x00010001 -> f=0x80018001.
REQ-033 Op 11, a=0x12345678, b=0x0000FFFF -> f=0x00005678, out_valid exactly 32 cycles after accept; b=0 -> f=0, also at 32 cycles.
REQ-034 Op 10, a=0xFFFF1234, b=0x00FF00FF -> f=0x00FF0034 after 16 cycles; in_valid pulsed while BUSY is ignored.
REQ-035 Hold out_ready=0 for 5 cycles -> f is stable; then out_ready=1 with a new op 0 request (a=0x5) on the same edge -> both handshakes complete, f=0x5 next cycle.
REQ-036 rst_n pulsed low mid-op-11 -> out_valid=0 immediately; in_ready=1 on the first clk edge after release; op 13 -> err=1, f=0.
